// File: rtl/dmem_mmio_responder.sv
// Data-side responder for the single-cycle MIPS core: word RAM plus a 256-byte MMIO page.
// Optional down-counting timer, STATUS.expired and irq are built only when DMEM_TIMER_EN is defined.
module dmem_mmio_responder #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [5:0] OFS_DISP   = 6'h00;
    localparam logic [5:0] OFS_CYCLE  = 6'h01;
    localparam logic [5:0] OFS_TIMER  = 6'h02;
    localparam logic [5:0] OFS_STATUS = 6'h03;

    logic [31:0] ram [DEPTH_WORDS];

    logic [15:0] disp_reg;
    logic [31:0] cycle_reg;
    logic        misalign_reg;
    logic [31:0] timer_val;
    logic        expired_val;

    logic          io;
    logic          aligned;
    logic          store_ok;
    logic          io_store;
    logic [AW-1:0] ram_idx;
    logic [5:0]    io_word;

    assign io       = (addr[31:8] == MMIO_BASE[31:8]);
    assign aligned  = (addr[1:0] == 2'b00);
    assign store_ok = memwrite && aligned;
    assign io_store = store_ok && io;
    assign ram_idx  = addr[AW+1:2];
    assign io_word  = addr[7:2];

    always_ff @(posedge clk) begin
        if (store_ok && !io) begin
            ram[ram_idx] <= writedata;
        end
    end

    // Misaligned stores never touch state; they only raise the sticky flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            disp_reg     <= '0;
            cycle_reg    <= '0;
            misalign_reg <= 1'b0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (io_store && io_word == OFS_DISP) begin
                disp_reg <= writedata[15:0];
            end
            if (memwrite && !aligned) begin
                misalign_reg <= 1'b1;
            end else if (io_store && io_word == OFS_STATUS && writedata[1]) begin
                misalign_reg <= 1'b0;
            end
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] timer_reg;
    logic        expired_reg;
    logic        timer_load;

    assign timer_load = io_store && io_word == OFS_TIMER;

    // A load pre-empts the decrement, so a load while at 1 produces no expiry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_reg   <= '0;
            expired_reg <= 1'b0;
        end else begin
            if (timer_load) begin
                timer_reg <= writedata;
            end else if (timer_reg != 32'd0) begin
                timer_reg <= timer_reg - 32'd1;
            end
            if (!timer_load && timer_reg == 32'd1) begin
                expired_reg <= 1'b1;
            end else if (io_store && io_word == OFS_STATUS && writedata[0]) begin
                expired_reg <= 1'b0;
            end
        end
    end

    assign timer_val   = timer_reg;
    assign expired_val = expired_reg;
`else
    assign timer_val   = '0;
    assign expired_val = 1'b0;
`endif

    assign irq = expired_val;

    always_comb begin
        readdata = '0;
        if (io) begin
            case (io_word)
                OFS_DISP:   readdata = {16'b0, disp_reg};
                OFS_CYCLE:  readdata = cycle_reg;
                OFS_TIMER:  readdata = timer_val;
                OFS_STATUS: readdata = {30'b0, misalign_reg, expired_val};
                default:    readdata = '0;
            endcase
        end else begin
            readdata = ram[ram_idx];
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    logic [6:0] hex_digits [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hex
            assign hex_digits[gi] = seg7(disp_reg[gi*4 +: 4]);
        end
    endgenerate

    assign hex0 = hex_digits[0];
    assign hex1 = hex_digits[1];
    assign hex2 = hex_digits[2];
    assign hex3 = hex_digits[3];
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder; timer checks follow the DMEM_TIMER_EN build.
module tb_dmem_mmio_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_DISP   = 32'hFFFF_FF00;
    localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF04;
    localparam logic [31:0] A_TIMER  = 32'hFFFF_FF08;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF0C;
    localparam logic [6:0]  SEG_0    = 7'b1000000;

    dmem_mmio_responder #(.DEPTH_WORDS(64), .MMIO_BASE(32'hFFFF_FF00)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata), .irq(irq),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
        $display("check %-14s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memwrite = 1'b0;
        addr     = a;
        #1;
        chk(tag, readdata, exp);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        step();
        memwrite  = 1'b0;
    endtask

    initial begin
        logic [31:0] cyc;
        reset = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
        step();
        step();
        chk("rst_hex0", 32'(hex0), 32'(SEG_0));
        chk("rst_hex1", 32'(hex1), 32'(SEG_0));
        chk("rst_hex2", 32'(hex2), 32'(SEG_0));
        chk("rst_hex3", 32'(hex3), 32'(SEG_0));
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        rd("cycle0", A_CYCLE, 32'd0);
        step(); rd("cycle1", A_CYCLE, 32'd1);
        step(); rd("cycle2", A_CYCLE, 32'd2);
        step(); rd("cycle3", A_CYCLE, 32'd3);

        // CYCLE is read-only: one edge later it has simply advanced
        cyc = readdata;
        sw(A_CYCLE, 32'd0);
        rd("cycle_ro", A_CYCLE, cyc + 32'd1);

        sw(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);

        sw(A_DISP, 32'h0000_12AF);
        chk("hex0_F", 32'(hex0), 32'(7'b0001110));
        chk("hex1_A", 32'(hex1), 32'(7'b0001000));
        chk("hex2_2", 32'(hex2), 32'(7'b0100100));
        chk("hex3_1", 32'(hex3), 32'(7'b1111001));
        rd("disp_rd", A_DISP, 32'h0000_12AF);

        sw(32'hFFFF_FF10, 32'h1234_5678);
        rd("unmapped", 32'hFFFF_FF10, 32'd0);

        sw(32'h0000_0012, 32'h0000_5555);
        rd("mis_ram", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("mis_load", 32'h0000_0013, 32'hDEAD_BEEF);
        rd("mis_status", A_STATUS, 32'd2);
        sw(A_STATUS, 32'd2);
        rd("mis_clr", A_STATUS, 32'd0);

`ifdef DMEM_TIMER_EN
        sw(A_TIMER, 32'd3);
        rd("tmr_3", A_TIMER, 32'd3);
        step(); rd("tmr_2", A_TIMER, 32'd2);
        chk("irq_at2", 32'(irq), 32'd0);
        step(); rd("tmr_1", A_TIMER, 32'd1);
        chk("irq_at1", 32'(irq), 32'd0);
        step(); rd("tmr_0", A_TIMER, 32'd0);
        chk("irq_set", 32'(irq), 32'd1);
        rd("stat_exp", A_STATUS, 32'd1);
        step(); rd("tmr_hold", A_TIMER, 32'd0);
        sw(A_STATUS, 32'd1);
        rd("stat_clr", A_STATUS, 32'd0);
        chk("irq_clr", 32'(irq), 32'd0);

        // W1C in the same cycle as the 1->0 step: set wins
        sw(A_TIMER, 32'd1);
        sw(A_STATUS, 32'd1);
        rd("set_wins", A_STATUS, 32'd1);
        chk("irq_win", 32'(irq), 32'd1);
        sw(A_STATUS, 32'd1);
        rd("stat_clr2", A_STATUS, 32'd0);

        // load pre-empts the decrement
        sw(A_TIMER, 32'd5);
        sw(A_TIMER, 32'd9);
        rd("load_wins", A_TIMER, 32'd9);
        step(); rd("tmr_8", A_TIMER, 32'd8);
        sw(A_TIMER, 32'd0);
        step(); rd("load0_stat", A_STATUS, 32'd0);

        // reset mid-countdown: no expiry event
        sw(A_TIMER, 32'd2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        rd("rst_tmr", A_TIMER, 32'd0);
        rd("rst_stat", A_STATUS, 32'd0);
        step(); rd("rst_stat2", A_STATUS, 32'd0);
        chk("rst_irq2", 32'(irq), 32'd0);
        chk("rst_disp", 32'(hex0), 32'(SEG_0));
`else
        sw(A_TIMER, 32'd5);
        rd("notmr_rd", A_TIMER, 32'd0);
        chk("notmr_irq", 32'(irq), 32'd0);
        step(); step();
        rd("notmr_rd2", A_TIMER, 32'd0);
        rd("notmr_stat", A_STATUS, 32'd0);
        chk("notmr_irq2", 32'(irq), 32'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_disp", 32'(hex0), 32'(SEG_0));
        rd("rst_cycle", A_CYCLE, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
